// File: rtl/s298_scan_ctrl.sv
// Scan/capture/run sequencer that owns the s298 state register (pseudo-I/O G10..G23 / n19..n84).
// Define S298_SCAN_PARITY_EN to add the so_par scan-out parity output.
module s298_scan_ctrl #(
    parameter int STATE_W = 14,
    parameter int LEN_W   = 8
) (
    input  logic               CK,
    input  logic               RN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               abort,
    input  logic               si,
    output logic               so,
    output logic [STATE_W-1:0] state_q,
    input  logic [STATE_W-1:0] next_d,
    output logic               busy,
`ifdef S298_SCAN_PARITY_EN
    output logic               done,
    output logic               so_par
`else
    output logic               done
`endif
);

    // One down-counter serves both the SHIFT length and the RUN length.
    localparam int SH_W  = $clog2(STATE_W + 1);
    localparam int CNT_W = (LEN_W > SH_W) ? LEN_W : SH_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPT,
        ST_RUN,
        ST_DONE
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;
`ifdef S298_SCAN_PARITY_EN
    logic               par_q, par_d;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
`ifdef S298_SCAN_PARITY_EN
        par_d   = par_q;
`endif
        unique case (fsm_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        2'b00: begin
                            fsm_d = ST_SHIFT;
                            cnt_d = CNT_W'(STATE_W);
`ifdef S298_SCAN_PARITY_EN
                            par_d = 1'b0;
`endif
                        end
                        2'b01: fsm_d = ST_CAPT;
                        2'b10: begin
                            fsm_d = (cmd_len == '0) ? ST_DONE : ST_RUN;
                            cnt_d = CNT_W'(cmd_len);
                        end
                        default: fsm_d = ST_DONE;
                    endcase
                end
            end
            ST_SHIFT: begin
                // An aborted cycle leaves the register untouched.
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = {si, state_q[STATE_W-1:1]};
`ifdef S298_SCAN_PARITY_EN
                    par_d   = par_q ^ state_q[0];
`endif
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) fsm_d = ST_DONE;
                end
            end
            ST_CAPT: begin
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = next_d;
                    fsm_d   = ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = next_d;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) fsm_d = ST_DONE;
                end
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with fsm_q.
        busy_d      = (fsm_d == ST_SHIFT) || (fsm_d == ST_CAPT) || (fsm_d == ST_RUN);
        cmd_ready_d = (fsm_d == ST_IDLE);
        done_d      = (fsm_q == ST_DONE);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef S298_SCAN_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef S298_SCAN_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign so        = state_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = cmd_ready_q;
`ifdef S298_SCAN_PARITY_EN
    assign so_par    = par_q;
`endif

endmodule

// File: tb/tb_s298_scan_ctrl.sv
// Testbench for s298_scan_ctrl: directed vector table, reset/abort sequences and a randomized
// command stream checked against a transaction-level model (build with S298_SCAN_PARITY_EN for so_par).
module tb_s298_scan_ctrl;

    localparam int W  = 14;
    localparam int LW = 8;

    logic          CK        = 1'b0;
    logic          RN        = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'd0;
    logic [LW-1:0] cmd_len   = '0;
    logic          abort     = 1'b0;
    logic          si        = 1'b0;
    logic          cmd_ready;
    logic          so;
    logic [W-1:0]  state_q;
    logic [W-1:0]  next_d;
    logic          busy;
    logic          done;
`ifdef S298_SCAN_PARITY_EN
    logic          so_par;
`endif

    logic          nd_force = 1'b0;
    logic [W-1:0]  nd_val   = '0;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [W-1:0]  mstate = '0;
    logic          mpar   = 1'b0;

    always #5 CK = ~CK;

    // Stand-in for the combinational core: a twisted ring with one tap.
    function automatic logic [W-1:0] core_f(input logic [W-1:0] s);
        return {s[W-2:0], ~(s[W-1] ^ s[6])};
    endfunction

    assign next_d = nd_force ? nd_val : core_f(state_q);

    s298_scan_ctrl #(.STATE_W(W), .LEN_W(LW)) dut (
        .CK        (CK),
        .RN        (RN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .si        (si),
        .so        (so),
        .state_q   (state_q),
        .next_d    (next_d),
        .busy      (busy),
`ifdef S298_SCAN_PARITY_EN
        .done      (done),
        .so_par    (so_par)
`else
        .done      (done)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int busy_cycles(input logic [1:0] op, input int len);
        case (op)
            2'd0:    return W;
            2'd1:    return 1;
            2'd2:    return len;
            default: return 0;
        endcase
    endfunction

    function automatic int done_lat(input logic [1:0] op, input int len, input int a);
        if (a != 0) return 0;
        case (op)
            2'd0:    return W + 1;
            2'd1:    return 2;
            2'd2:    return len + 1;
            default: return 1;
        endcase
    endfunction

    function automatic int updates(input logic [1:0] op, input int len, input int a);
        if (a != 0) return a - 1;
        return busy_cycles(op, len);
    endfunction

    function automatic logic [W-1:0] model_state(input logic [W-1:0] start, input logic [1:0] op,
                                                 input int len, input logic [W-1:0] vec, input int a,
                                                 input logic frc, input logic [W-1:0] fval);
        int n;
        int r;
        logic [W-1:0] s;
        n = updates(op, len, a);
        s = start;
        if (op == 2'd0) begin
            // n serial bits: old vector moves down by n, the first n si bits fill the top.
            r = (int'(start) >> n) | ((int'(vec) & ((1 << n) - 1)) << (W - n));
            s = r[W-1:0];
        end else begin
            for (int k = 0; k < n; k++) s = frc ? fval : core_f(s);
        end
        return s;
    endfunction

    function automatic logic model_par(input logic [W-1:0] start, input logic [1:0] op, input int len,
                                       input int a, input logic prev);
        logic p;
        if (op != 2'd0) return prev;
        p = 1'b0;
        for (int k = 0; k < updates(op, len, a); k++) p = p ^ start[k];
        return p;
    endfunction

    // Issue one command right after an edge with the DUT idle; checks every cycle up to completion.
    task automatic run_cmd(input string name, input logic [1:0] op, input int len, input logic [W-1:0] vec,
                           input int a, input logic frc, input logic [W-1:0] fval, input logic noise,
                           input logic [W-1:0] exp_state, input int exp_lat, input logic exp_par);
        logic [W-1:0] start;
        int bn, lat, k_end, nsh;
        start = mstate;
        bn    = (a != 0) ? a : busy_cycles(op, len);
        lat   = done_lat(op, len, a);
        k_end = (a != 0) ? a : lat;
        nsh   = (op == 2'd0) ? updates(op, len, a) : 0;
        nd_force  = frc;
        nd_val    = fval;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        @(posedge CK); #1;
        for (int k = 0; k <= k_end; k++) begin
            chk($sformatf("%s busy k%0d", name, k), 32'(busy), 32'(k < bn));
            chk($sformatf("%s done k%0d", name, k), 32'(done), 32'(exp_lat != 0 && k == exp_lat));
            chk($sformatf("%s ready k%0d", name, k), 32'(cmd_ready), 32'(k >= k_end));
            if (k < nsh) chk($sformatf("%s so k%0d", name, k), 32'(so), 32'(start[k]));
            if (k == k_end) break;
            si = 1'b0;
            if (k < W) si = vec[k];
            abort     = (a != 0 && k + 1 == a) || (noise && a == 0 && k + 1 == lat);
            cmd_valid = noise;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_len   = '0;
            @(posedge CK); #1;
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        si        = 1'b0;
        chk($sformatf("%s state", name), 32'(state_q), 32'(exp_state));
`ifdef S298_SCAN_PARITY_EN
        chk($sformatf("%s so_par", name), 32'(so_par), 32'(exp_par));
`endif
        mstate = exp_state;
        mpar   = exp_par;
    endtask

    typedef struct {
        logic [1:0]   op;
        int           len;
        logic [W-1:0] vec;
        int           a;
        logic         frc;
        logic [W-1:0] fval;
        logic [W-1:0] exp_state;
        int           exp_lat;
        logic         exp_par;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op;
        int           len, a, bn, done_seen;
        logic [W-1:0] vec, fval, es;
        logic         frc, noise, ep;

        //                op    len vec       a  frc   fval      state     lat par
        tbl[0]  = '{2'd0, 0, 14'h2A5B, 0, 1'b0, 14'h0000, 14'h2A5B, 15, 1'b0};
        tbl[1]  = '{2'd0, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h0000, 15, 1'b0};
        tbl[2]  = '{2'd2, 3, 14'h0000, 0, 1'b0, 14'h0000, 14'h0007, 4,  1'b0};
        tbl[3]  = '{2'd2, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h0007, 1,  1'b0};
        tbl[4]  = '{2'd0, 0, 14'h0001, 0, 1'b0, 14'h0000, 14'h0001, 15, 1'b1};
        tbl[5]  = '{2'd1, 0, 14'h0000, 0, 1'b1, 14'h1C3F, 14'h1C3F, 2,  1'b1};
        tbl[6]  = '{2'd3, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h1C3F, 1,  1'b1};
        tbl[7]  = '{2'd0, 0, 14'h3FFF, 6, 1'b0, 14'h0000, 14'h3EE1, 0,  1'b1};
        tbl[8]  = '{2'd0, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h0000, 15, 1'b1};
        tbl[9]  = '{2'd0, 0, 14'h2A5B, 0, 1'b0, 14'h0000, 14'h2A5B, 15, 1'b0};
        tbl[10] = '{2'd0, 0, 14'h0001, 0, 1'b0, 14'h0000, 14'h0001, 15, 1'b0};
        tbl[11] = '{2'd0, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h0000, 15, 1'b1};
        tbl[12] = '{2'd3, 0, 14'h0000, 0, 1'b0, 14'h0000, 14'h0000, 1,  1'b1};
        tbl[13] = '{2'd1, 0, 14'h0000, 1, 1'b1, 14'h1555, 14'h0000, 0,  1'b1};

        // Reset values while RN is held low.
        #12;
        chk("reset state_q", 32'(state_q), 32'd0);
        chk("reset so", 32'(so), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef S298_SCAN_PARITY_EN
        chk("reset so_par", 32'(so_par), 32'd0);
`endif
        RN = 1'b1;
        @(posedge CK); #1;

        for (int i = 0; i < 14; i++) begin
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].len, tbl[i].vec, tbl[i].a, tbl[i].frc,
                    tbl[i].fval, 1'(i % 2), tbl[i].exp_state, tbl[i].exp_lat, tbl[i].exp_par);
        end

        // Asynchronous reset in the middle of a SHIFT (shift cycle 5).
        cmd_op    = 2'd0;
        cmd_valid = 1'b1;
        si        = 1'b1;
        @(posedge CK); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge CK);
        #2 RN = 1'b0;
        #1;
        chk("midrst state_q", 32'(state_q), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst done", 32'(done), 32'd0);
`ifdef S298_SCAN_PARITY_EN
        chk("midrst so_par", 32'(so_par), 32'd0);
`endif
        @(posedge CK); #1;
        RN = 1'b1;
        si = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge CK); #1;
            if (done) done_seen = 1;
        end
        chk("midrst no done", 32'(done_seen), 32'd0);
        chk("midrst state held", 32'(state_q), 32'd0);
        mstate = '0;
        mpar   = 1'b0;

        // Randomized command stream against the model.
        for (int i = 0; i < 60; i++) begin
            op    = 2'($urandom_range(0, 3));
            len   = int'($urandom_range(0, 12));
            vec   = W'($urandom);
            frc   = 1'($urandom_range(0, 1));
            fval  = W'($urandom);
            noise = 1'($urandom_range(0, 1));
            bn    = busy_cycles(op, len);
            a     = 0;
            if (bn > 0 && $urandom_range(0, 3) == 0) a = int'($urandom_range(1, bn));
            es = model_state(mstate, op, len, vec, a, frc, fval);
            ep = model_par(mstate, op, len, a, mpar);
            run_cmd($sformatf("rnd%0d", i), op, len, vec, a, frc, fval, noise, es,
                    done_lat(op, len, a), ep);
        end

        // Longest RUN the counter supports.
        es = model_state(mstate, 2'd2, 255, '0, 0, 1'b0, '0);
        run_cmd("run255", 2'd2, 255, '0, 0, 1'b0, '0, 1'b0, es, 256, mpar);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
